// File: rtl/banked_mem_responder_if.sv
// Cache controller <-> main memory request bus.
// Handshake: a request is a one-hot rd/wr pulse with addr/data_in; it is taken
// at the rising edge ending a cycle in which err and stall are both low.
// While stall is high the requester holds rd/wr/addr/data_in unchanged.
interface banked_mem_responder_if;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    modport master (
        output rd, wr, addr, data_in,
        input  data_out, stall, busy, err
    );

    modport slave (
        input  rd, wr, addr, data_in,
        output data_out, stall, busy, err
    );
endinterface

// File: rtl/banked_mem_responder.sv
// Four-bank word-interleaved main memory model. Each bank is held busy for
// BUSY_CYC cycles after an accepted access; read data appears RD_LAT cycles
// after acceptance through a small valid/data shift pipeline.
module banked_mem_responder #(
    parameter int ROWS_LOG2 = 13,
    parameter int BUSY_CYC  = 4,
    parameter int RD_LAT    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    banked_mem_responder_if.slave    bus
);

    localparam int IDX_W = ROWS_LOG2 + 2;
    localparam int WORDS = 1 << IDX_W;

    // Read pipeline slot: the only state machine in the block.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_VALID = 1'b1
    } slot_state_t;

    typedef struct packed {
        slot_state_t st;
        logic [15:0] data;
    } slot_t;

    logic [15:0]          mem [WORDS];
    logic [2:0]           cnt [4];
    slot_t                pipe [RD_LAT];
    logic [3:0]           busy_w;
    logic [1:0]           bank;
    logic [ROWS_LOG2-1:0] row;
    logic [IDX_W-1:0]     idx;
    logic                 req_one;
    logic                 err_w;
    logic                 stall_w;
    logic                 accept;

    // Address split: low bit is the byte lane, bits above the row are aliased away.
    assign bank = bus.addr[2:1];
    assign row  = bus.addr[ROWS_LOG2+2:3];
    assign idx  = {row, bank};

    // Request decode; an errored request never reaches the banks.
    assign req_one = bus.rd ^ bus.wr;
    assign err_w   = (bus.rd & bus.wr) | ((bus.rd | bus.wr) & bus.addr[0]);
    assign stall_w = req_one & ~bus.addr[0] & busy_w[bank];
    assign accept  = req_one & ~err_w & ~stall_w;

    // Busy flags derived from the per-bank occupancy counters.
    always_comb begin
        busy_w = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            busy_w[b] = (cnt[b] != 3'd0);
        end
    end

    // Bank occupancy counters: reload on accept, otherwise count down to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                cnt[b] <= 3'd0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (accept && (bank == 2'(b))) begin
                    cnt[b] <= 3'(BUSY_CYC);
                end else if (cnt[b] != 3'd0) begin
                    cnt[b] <= cnt[b] - 3'd1;
                end
            end
        end
    end

    // Storage array: contents survive reset, written at the accept edge.
    always_ff @(posedge clk) begin
        if (accept && bus.wr) begin
            mem[idx] <= bus.data_in;
        end
    end

    // Read pipeline: slot 0 captures the array word on a read accept, then shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pipe[k] <= '{st: SLOT_EMPTY, data: 16'h0000};
            end
        end else begin
            if (accept && bus.rd) begin
                pipe[0] <= '{st: SLOT_VALID, data: mem[idx]};
            end else begin
                pipe[0] <= '{st: SLOT_EMPTY, data: 16'h0000};
            end
            for (int k = 1; k < RD_LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    // Outputs: data_out is zero unless the last slot holds a valid word.
    assign bus.data_out = (pipe[RD_LAT-1].st == SLOT_VALID) ? pipe[RD_LAT-1].data : 16'h0000;
    assign bus.stall    = stall_w;
    assign bus.busy     = busy_w;
    assign bus.err      = err_w;

endmodule

// File: tb/tb_banked_mem_responder.sv
// Bench for banked_mem_responder: a cycle-indexed model (word store, per-bank
// busy-until cycle, queue of due read words) checked every cycle, plus
// literal expectations for the directed scenarios.
module tb_banked_mem_responder;

    localparam int BUSY_CYC = 4;
    localparam int RD_LAT   = 2;

    logic clk;
    logic rst;

    banked_mem_responder_if bus ();

    banked_mem_responder #(
        .ROWS_LOG2 (13),
        .BUSY_CYC  (BUSY_CYC),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp;
    int n_bad;

    // Model state
    int          cyc;
    int          busy_until [4];
    logic [15:0] mmem [int];
    logic [15:0] exp_q [$];
    int          due_q [$];

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Driver: inputs change 1 time unit after the rising edge.
    task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        bus.rd      = r;
        bus.wr      = w;
        bus.addr    = a;
        bus.data_in = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    // Model: applies the acceptance rules at each rising edge.
    initial begin
        cyc = 0;
        for (int b = 0; b < 4; b++) busy_until[b] = -1;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int b = 0; b < 4; b++) busy_until[b] = -1;
                exp_q.delete();
                due_q.delete();
            end else begin
                int  b;
                int  widx;
                logic one;
                logic e;
                logic st;
                b    = int'(bus.addr[2:1]);
                widx = int'(bus.addr[15:3]) * 4 + b;
                one  = bus.rd ^ bus.wr;
                e    = (bus.rd & bus.wr) | ((bus.rd | bus.wr) & bus.addr[0]);
                st   = one && !bus.addr[0] && (busy_until[b] >= cyc);
                if (one && !e && !st) begin
                    if (bus.wr) begin
                        mmem[widx] = bus.data_in;
                    end else begin
                        due_q.push_back(cyc + RD_LAT);
                        exp_q.push_back(mmem.exists(widx) ? mmem[widx] : 16'h0000);
                    end
                    busy_until[b] = cyc + BUSY_CYC;
                end
            end
            cyc++;
        end
    end

    // Scoreboard: every cycle, mid-period, compare all outputs to the model.
    initial begin
        forever begin
            logic [3:0]  eb;
            logic [15:0] ed;
            logic        ee;
            logic        es;
            @(negedge clk);
            eb = 4'b0000;
            for (int b = 0; b < 4; b++) eb[b] = !rst && (busy_until[b] >= cyc);
            ed = 16'h0000;
            while (due_q.size() > 0 && due_q[0] < cyc) begin
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
            end
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                ed = rst ? 16'h0000 : exp_q[0];
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
            end
            ee = (bus.rd & bus.wr) | ((bus.rd | bus.wr) & bus.addr[0]);
            es = (bus.rd ^ bus.wr) & ~bus.addr[0] & eb[bus.addr[2:1]];
            chk("sb_busy", {12'h0, bus.busy}, {12'h0, eb});
            chk("sb_data", bus.data_out, ed);
            chk("sb_err", {15'h0, bus.err}, {15'h0, ee});
            chk("sb_stall", {15'h0, bus.stall}, {15'h0, es});
        end
    end

    // Directed scenarios with literal expectations
    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        bus.addr = 16'h0000;
        bus.data_in = 16'h0000;
        @(negedge clk);
        chk("rst_busy", {12'h0, bus.busy}, 16'h0000);
        chk("rst_data", bus.data_out, 16'h0000);
        idle(2);
        rst = 1'b0;
        idle(1);

        // Write then read of the same word, read timing
        drive(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        idle(4);
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        @(negedge clk); chk("rd_stall0", {15'h0, bus.stall}, 16'h0000);
        idle(1); @(negedge clk); chk("rd_c6", bus.data_out, 16'h0000);
        idle(1); @(negedge clk); chk("rd_c7", bus.data_out, 16'hBEEF);
        idle(1); @(negedge clk); chk("rd_c8", bus.data_out, 16'h0000);

        // Same-bank stall
        drive(1'b0, 1'b1, 16'h000A, 16'h1234);
        idle(4);
        drive(1'b0, 1'b1, 16'h0002, 16'h5555);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 16'h000A, 16'h0000);
            @(negedge clk);
            chk("stall_hi", {15'h0, bus.stall}, 16'h0001);
            chk("stall_busy", {12'h0, bus.busy}, 16'h0002);
        end
        drive(1'b1, 1'b0, 16'h000A, 16'h0000);
        @(negedge clk); chk("stall_lo", {15'h0, bus.stall}, 16'h0000);
        idle(2); @(negedge clk); chk("stall_data", bus.data_out, 16'h1234);

        // Four banks in flight
        idle(3);
        drive(1'b0, 1'b1, 16'h0000, 16'hA000);
        drive(1'b0, 1'b1, 16'h0002, 16'hA001);
        drive(1'b0, 1'b1, 16'h0004, 16'hA002);
        drive(1'b0, 1'b1, 16'h0006, 16'hA003);
        idle(4);
        drive(1'b1, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk); chk("b4_stall0", {15'h0, bus.stall}, 16'h0000);
        drive(1'b1, 1'b0, 16'h0002, 16'h0000);
        @(negedge clk); chk("b4_stall1", {15'h0, bus.stall}, 16'h0000);
        drive(1'b1, 1'b0, 16'h0004, 16'h0000);
        @(negedge clk); chk("b4_d2", bus.data_out, 16'hA000);
        drive(1'b1, 1'b0, 16'h0006, 16'h0000);
        @(negedge clk); chk("b4_d3", bus.data_out, 16'hA001);
        idle(1);
        @(negedge clk); chk("b4_busy", {12'h0, bus.busy}, 16'h000F);
        chk("b4_d4", bus.data_out, 16'hA002);
        idle(1); @(negedge clk); chk("b4_d5", bus.data_out, 16'hA003);
        idle(1); @(negedge clk); chk("b4_d6", bus.data_out, 16'h0000);

        // Illegal requests
        idle(4);
        drive(1'b0, 1'b1, 16'h0020, 16'h7777);
        drive(1'b1, 1'b1, 16'h0000, 16'hDEAD);
        @(negedge clk);
        chk("err_rdwr", {15'h0, bus.err}, 16'h0001);
        chk("err_rdwr_stall", {15'h0, bus.stall}, 16'h0000);
        chk("err_rdwr_busy", {12'h0, bus.busy}, 16'h0001);
        drive(1'b1, 1'b0, 16'h0003, 16'h0000);
        @(negedge clk);
        chk("err_odd", {15'h0, bus.err}, 16'h0001);
        chk("err_odd_stall", {15'h0, bus.stall}, 16'h0000);
        drive(1'b0, 1'b1, 16'h0011, 16'hDEAD);
        @(negedge clk);
        chk("err_wr", {15'h0, bus.err}, 16'h0001);
        chk("err_busy_same", {12'h0, bus.busy}, 16'h0001);
        idle(1); @(negedge clk); chk("err_no_data", bus.data_out, 16'h0000);
        idle(4);
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(2); @(negedge clk); chk("err_array_kept", bus.data_out, 16'hBEEF);

        // Reset mid-read
        idle(5);
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", {12'h0, bus.busy}, 16'h0000);
        chk("mid_rst_data", bus.data_out, 16'h0000);
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            @(negedge clk);
            chk("post_rst_data", bus.data_out, 16'h0000);
        end
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(2); @(negedge clk); chk("post_rst_read", bus.data_out, 16'hBEEF);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
